fifo_ddr3_writer: RTL and testbench
===================================

Name: fifo_ddr3_writer

Overview:
- Read-side consumer of the 256-bit x16 sample FIFO in the ISFET readout path.
- Pops one 256-bit word at a time from a standard-read FIFO (dout valid 1 cycle after rd_en) and issues it as a single DDR3 MIG write (app command + write-data interfaces).
- Address advances linearly over a circular buffer region.
- Sits between the sample FIFO and the MIG user interface, ahead of the PCIe read-back logic.

Parameters:
- ADDR_W, 28, width of app_addr.
- ADDR_INC, 8, app_addr increment per 256-bit word.
- ADDR_BASE, 0, first address of the circular region.
- ADDR_LAST, 28'h0FFFFF8, last address written before wrapping. Must be ADDR_BASE + k*ADDR_INC.

Ports:
- clk, input, 1, single clock (MIG ui_clk domain).
- rst, input, 1, synchronous active-high reset.
- en, input, 1, enable. Deassertion stops after the in-flight word.
- calib_done, input, 1, MIG init_calib_complete.
- fifo_dout, input, 256, FIFO read data.
- fifo_empty, input, 1, FIFO empty.
- fifo_rdy, input, 1, FIFO reset-complete indication.
- fifo_rd_en, output, 1, FIFO pop strobe.
- app_rdy, input, 1, MIG command ready.
- app_wdf_rdy, input, 1, MIG write-data ready.
- app_en, output, 1, command valid.
- app_cmd, output, 3, command. Always 3'b000 (write).
- app_addr, output, ADDR_W, command address.
- app_wdf_data, output, 256, write data.
- app_wdf_wren, output, 1, write-data valid.
- app_wdf_end, output, 1, equals app_wdf_wren (BL8, one beat per burst).
- app_wdf_mask, output, 32, always 0.
- wr_count, output, 32, words fully committed since reset. Wraps at 2^32.
- wrap, output, 1, one-cycle pulse when the address wraps to ADDR_BASE.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; addr=ADDR_BASE; wr_count=0.
  - fifo_rd_en, app_en, app_wdf_wren, wrap, busy all 0; app_wdf_data=0.
  - Reset mid-transaction abandons the word; the MIG handshake is dropped without completion.
- States:
  - IDLE: if en & calib_done & fifo_rdy & ~fifo_empty, assert fifo_rd_en for exactly that cycle and go to FETCH. Otherwise stay.
  - FETCH: capture fifo_dout into the data register; cmd_done=0, dat_done=0. Go to ISSUE.
  - ISSUE: app_en = ~cmd_done and app_wdf_wren = ~dat_done, driven from registers and asserted the cycle after FETCH.
    - Command accepted when app_en & app_rdy: set cmd_done.
    - Data accepted when app_wdf_wren & app_wdf_rdy: set dat_done.
    - The two handshakes are independent and may complete in either order or in the same cycle.
    - Once asserted, a valid stays high until accepted. app_addr and app_wdf_data are held stable while their valid is high.
    - When both are done (including both accepted in one cycle), the following cycle:
      - wr_count+1;
      - addr = (addr==ADDR_LAST) ? ADDR_BASE : addr+ADDR_INC;
      - wrap=1 for that cycle only if wrapped;
      - go to IDLE.
- Minimum period: 4 cycles per word (IDLE-FETCH-ISSUE-advance). No pipelining.
- en low while in FETCH or ISSUE: the word completes normally, then the block idles.
- calib_done or fifo_rdy falling mid-word: ignored until back in IDLE.
- fifo_rd_en is never asserted while fifo_empty=1, nor outside IDLE. This guarantees no FIFO underflow.
- Address arithmetic: modulo 2^ADDR_W. The compare against ADDR_LAST takes priority over the increment.

Decomposition:
- Shared package ddr3_pkg:
  - app_cmd encodings CMD_WRITE=3'b000, CMD_READ=3'b001.
  - Data width constant APP_DATA_W=256 and mask width APP_MASK_W=32.
  - Typedef wr_state_t enum {IDLE, FETCH, ISSUE}.
- One natural sub-module: ddr3_addr_gen. Holds the circular address counter with the wrap flag, reused later by the read-back side.

Test Plan:
- Reset sequencing: rst=1 for 3 cycles with fifo non-empty -> all outputs 0, app_addr=ADDR_BASE, no fifo_rd_en. Release -> first fifo_rd_en 1 cycle after calib_done=fifo_rdy=en=1.
- Single word, app_rdy=app_wdf_rdy=1: FIFO word 256'hA5..A5 -> app_en and app_wdf_wren high exactly 1 cycle, app_addr=0, data=A5..A5. wr_count=1 and next app_addr=8.
- Split back-pressure: app_wdf_rdy=1, app_rdy=0 for 5 cycles -> wren pulses once, app_en held 6 cycles with addr/data stable. Reverse ordering also tested; exactly one commit either way.
- Wrap: ADDR_LAST=24, 5 words -> addresses 0, 8, 16, 24, 0. wrap pulses once, after the 4th commit. wr_count=5.
- Empty/enable: FIFO empties mid-stream -> no rd_en while empty. en dropped during ISSUE -> current word commits, then busy=0 and no further pops.
- Reset mid-ISSUE with app_rdy=0: rst asserted -> next cycle app_en=0, state IDLE, wr_count and addr back to 0.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 MIG user-interface blocks: command
// encodings, data/mask widths and the writer state type.
package ddr3_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int APP_DATA_W = 256;
  localparam int APP_MASK_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } wr_state_t;

endpackage

// File: rtl/fifo_ddr3_writer_if.sv
// Sample-FIFO read port plus MIG command/write-data channels.
// master = the writer, slave = the FIFO/MIG side.
interface fifo_ddr3_writer_if #(
  parameter int ADDR_W = 28
);
  import ddr3_pkg::*;

  logic [APP_DATA_W-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rdy;
  logic                  fifo_rd_en;

  logic                  app_rdy;
  logic                  app_wdf_rdy;
  logic                  app_en;
  logic [2:0]            app_cmd;
  logic [ADDR_W-1:0]     app_addr;
  logic [APP_DATA_W-1:0] app_wdf_data;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic [APP_MASK_W-1:0] app_wdf_mask;

  modport master (
    input  fifo_dout, fifo_empty, fifo_rdy, app_rdy, app_wdf_rdy,
    output fifo_rd_en, app_en, app_cmd, app_addr, app_wdf_data,
           app_wdf_wren, app_wdf_end, app_wdf_mask
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_rdy, app_rdy, app_wdf_rdy,
    input  fifo_rd_en, app_en, app_cmd, app_addr, app_wdf_data,
           app_wdf_wren, app_wdf_end, app_wdf_mask
  );

endinterface

// File: rtl/ddr3_addr_gen.sv
// Circular address counter over [ADDR_BASE, ADDR_LAST] in ADDR_INC steps.
// o_wrap pulses for one cycle together with the address returning to base.
module ddr3_addr_gen
  import ddr3_pkg::*;
#(
  parameter int                 ADDR_W    = 28,
  parameter int unsigned        ADDR_INC  = 8,
  parameter logic [ADDR_W-1:0]  ADDR_BASE = '0,
  parameter logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(28'h0FFFFF8)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wrap
);

  logic [ADDR_W-1:0] r_addr;
  logic              r_wrap;
  logic              w_at_last;
  logic [ADDR_W-1:0] w_addr_nxt;

  // The end-of-region compare wins over the increment; the sum wraps mod 2^ADDR_W.
  assign w_at_last  = (r_addr == ADDR_LAST);
  assign w_addr_nxt = w_at_last ? ADDR_BASE : r_addr + ADDR_W'(ADDR_INC);

  // Advance the address on request and flag the wrap for exactly one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= ADDR_BASE;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= i_adv & w_at_last;
      if (i_adv) begin
        r_addr <= w_addr_nxt;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/fifo_ddr3_writer.sv
// Drains the 256-bit sample FIFO into DDR3, one MIG write per word, walking a
// circular address region. One word in flight at a time.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for en/calib/fifo ready and a word; pops when all true
//   FETCH | FIFO dout valid this cycle, latch it and clear handshake flags
//   ISSUE | drive app_en / app_wdf_wren until each is accepted; once both
//         | are done, commit (count + address advance) and return to IDLE
module fifo_ddr3_writer
  import ddr3_pkg::*;
#(
  parameter int                 ADDR_W    = 28,
  parameter int unsigned        ADDR_INC  = 8,
  parameter logic [ADDR_W-1:0]  ADDR_BASE = '0,
  parameter logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(28'h0FFFFF8)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_calib_done,
  fifo_ddr3_writer_if.master  bus,
  output logic [31:0]         o_wr_count,
  output logic                o_wrap,
  output logic                o_busy
);

  wr_state_t             r_state;
  wr_state_t             w_state_nxt;
  logic                  r_cmd_done;
  logic                  r_dat_done;
  logic [APP_DATA_W-1:0] r_wdf_data;
  logic [31:0]           r_wr_count;

  logic                  w_rd_en;
  logic                  w_app_en;
  logic                  w_wdf_wren;
  logic                  w_advance;
  logic                  w_cmd_acc;
  logic                  w_dat_acc;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_wrap;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and strobes. The pop is gated by reset so a word is never
  // pulled out of the FIFO only to be discarded.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_app_en    = 1'b0;
    w_wdf_wren  = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_rst && i_en && i_calib_done && bus.fifo_rdy && !bus.fifo_empty) begin
          w_rd_en     = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_app_en   = ~r_cmd_done;
        w_wdf_wren = ~r_dat_done;
        if (r_cmd_done && r_dat_done) begin
          w_advance   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_cmd_acc = w_app_en & bus.app_rdy;
  assign w_dat_acc = w_wdf_wren & bus.app_wdf_rdy;

  // Data latch, independent handshake tracking and the commit counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd_done <= 1'b0;
      r_dat_done <= 1'b0;
      r_wdf_data <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == FETCH) begin
        r_wdf_data <= bus.fifo_dout;
        r_cmd_done <= 1'b0;
        r_dat_done <= 1'b0;
      end else begin
        if (w_cmd_acc) begin
          r_cmd_done <= 1'b1;
        end
        if (w_dat_acc) begin
          r_dat_done <= 1'b1;
        end
      end
      if (w_advance) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  ddr3_addr_gen #(
    .ADDR_W    (ADDR_W),
    .ADDR_INC  (ADDR_INC),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_LAST (ADDR_LAST)
  ) u_addr_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_adv  (w_advance),
    .o_addr (w_addr),
    .o_wrap (w_wrap)
  );

  assign bus.fifo_rd_en   = w_rd_en;
  assign bus.app_en       = w_app_en;
  assign bus.app_cmd      = CMD_WRITE;
  assign bus.app_addr     = w_addr;
  assign bus.app_wdf_data = r_wdf_data;
  assign bus.app_wdf_wren = w_wdf_wren;
  assign bus.app_wdf_end  = w_wdf_wren;
  assign bus.app_wdf_mask = '0;

  assign o_wr_count = r_wr_count;
  assign o_wrap     = w_wrap;
  assign o_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_ddr3_writer.sv
// Bench for fifo_ddr3_writer: FIFO model feeding the DUT, scoreboard of
// expected (address, data) commits filled by the stimulus, and a monitor
// that pairs accepted commands with accepted data and checks them.
module tb_fifo_ddr3_writer;
  import ddr3_pkg::*;

  localparam int AW = 28;
  localparam logic [AW-1:0] LAST = 28'd24;

  localparam logic [255:0] W_A5  = {32{8'hA5}};
  localparam logic [255:0] W_3C  = {32{8'h3C}};
  localparam logic [255:0] W_DB  = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] W_12  = {16{16'h1234}};
  localparam logic [255:0] W_C0  = {8{32'hC0FF_EE00}};
  localparam logic [255:0] W_55  = {32{8'h55}};
  localparam logic [255:0] W_0F  = {16{16'h0F0F}};
  localparam logic [255:0] W_99  = {32{8'h99}};

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        calib_done;
  logic [31:0] wr_count;
  logic        wrap;
  logic        busy;

  fifo_ddr3_writer_if #(.ADDR_W(AW)) bus();

  fifo_ddr3_writer #(
    .ADDR_W    (AW),
    .ADDR_INC  (8),
    .ADDR_BASE ('0),
    .ADDR_LAST (LAST)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_calib_done (calib_done),
    .bus          (bus),
    .o_wr_count   (wr_count),
    .o_wrap       (wrap),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [255:0]  data;
  } commit_t;

  commit_t       exp_q[$];
  logic [AW-1:0] cmd_q[$];
  logic [255:0]  dat_q[$];
  logic [255:0]  fifo_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int en_cyc = 0;
  int wren_cyc = 0;
  int pops = 0;
  int wrap_cnt = 0;
  int wrap_at = -1;
  int last_rd_cyc = -1;
  int rd_gap = -1;

  function automatic void chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // FIFO model: dout updates right after a pop is seen; empty is refreshed
  // well after the clock edge so a pop decision is never disturbed.
  always @(negedge clk) begin
    if (bus.fifo_rd_en === 1'b1 && fifo_q.size() > 0) begin
      bus.fifo_dout = fifo_q.pop_front();
    end
  end

  always @(posedge clk) begin
    #2;
    bus.fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor / scoreboard.
  logic          pend_cmd;
  logic          pend_dat;
  logic [AW-1:0] pend_addr;
  logic [255:0]  pend_data;
  logic [AW-1:0] m_a;
  logic [255:0]  m_d;
  commit_t       m_e;

  always @(negedge clk) begin
    cyc++;
    if (rst !== 1'b0) begin
      cmd_q.delete();
      dat_q.delete();
      pend_cmd = 1'b0;
      pend_dat = 1'b0;
    end else begin
      if (bus.fifo_rd_en === 1'b1) begin
        chk("rd_en_while_empty", bus.fifo_empty, 1'b0);
        pops++;
        if (last_rd_cyc >= 0) rd_gap = cyc - last_rd_cyc;
        last_rd_cyc = cyc;
      end
      if (pend_cmd) begin
        chk("app_en_held", bus.app_en, 1'b1);
        chk("app_addr_stable", bus.app_addr, pend_addr);
      end
      if (pend_dat) begin
        chk("wren_held", bus.app_wdf_wren, 1'b1);
        chk("wdf_data_stable", bus.app_wdf_data, pend_data);
      end
      if (bus.app_wdf_wren || bus.app_wdf_end) begin
        chk("wdf_end", bus.app_wdf_end, bus.app_wdf_wren);
      end
      if (bus.app_en) en_cyc++;
      if (bus.app_wdf_wren) wren_cyc++;
      pend_cmd  = bus.app_en & ~bus.app_rdy;
      pend_addr = bus.app_addr;
      pend_dat  = bus.app_wdf_wren & ~bus.app_wdf_rdy;
      pend_data = bus.app_wdf_data;
      if (bus.app_en && bus.app_rdy) begin
        cmd_q.push_back(bus.app_addr);
        chk("app_cmd", bus.app_cmd, CMD_WRITE);
      end
      if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
        dat_q.push_back(bus.app_wdf_data);
        chk("wdf_mask", bus.app_wdf_mask, '0);
      end
      if (wrap) begin
        wrap_cnt++;
        wrap_at = wr_count;
        chk("wrap_addr", bus.app_addr, '0);
      end
      while (cmd_q.size() > 0 && dat_q.size() > 0) begin
        m_a = cmd_q.pop_front();
        m_d = dat_q.pop_front();
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_commit: got addr %0h data %0h expected none", m_a, m_d);
        end else begin
          m_e = exp_q.pop_front();
          chk("commit_addr", m_a, m_e.addr);
          chk("commit_data", m_d, m_e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [255:0] d, input bit expect_commit);
    fifo_q.push_back(d);
    if (expect_commit) exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic wait_count(input int target, input string name);
    int n = 0;
    while (wr_count !== 32'(target) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, wr_count, 32'(target));
    #1;
  endtask

  task automatic wait_valid(input bit which, input string name);
    int n = 0;
    while (((which ? bus.app_wdf_wren : bus.app_en) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if ((which ? bus.app_wdf_wren : bus.app_en) !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no valid after %0d cycles expected valid", name, n);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    en              = 1'b1;
    calib_done      = 1'b0;
    bus.fifo_dout   = '0;
    bus.fifo_empty  = 1'b1;
    bus.fifo_rdy    = 1'b1;
    bus.app_rdy     = 1'b1;
    bus.app_wdf_rdy = 1'b1;

    // Reset with a word waiting: nothing moves.
    push_word(28'd0, W_A5, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
      chk("rst_app_en", bus.app_en, 1'b0);
      chk("rst_wren", bus.app_wdf_wren, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wrap", wrap, 1'b0);
      chk("rst_addr", bus.app_addr, '0);
      chk("rst_count", wr_count, '0);
      chk("rst_data", bus.app_wdf_data, '0);
    end
    step();
    rst = 1'b0;
    step();
    chk("rd_en_before_calib", bus.fifo_rd_en, 1'b0);
    en_cyc = 0;
    wren_cyc = 0;
    calib_done = 1'b1;
    @(negedge clk);
    chk("rd_en_after_enable", bus.fifo_rd_en, 1'b1);

    // Single word, both readies high.
    wait_count(1, "single_count");
    chk("single_next_addr", bus.app_addr, 28'd8);
    chk("single_app_en_cycles", en_cyc, 1);
    chk("single_wren_cycles", wren_cyc, 1);

    // Command back-pressured for 5 cycles, data accepted at once.
    en_cyc = 0;
    wren_cyc = 0;
    bus.app_rdy = 1'b0;
    push_word(28'd8, W_3C, 1'b1);
    wait_valid(1'b0, "split_cmd_valid");
    repeat (5) step();
    bus.app_rdy = 1'b1;
    wait_count(2, "split_cmd_count");
    chk("split_cmd_app_en_cycles", en_cyc, 6);
    chk("split_cmd_wren_cycles", wren_cyc, 1);

    // Data back-pressured for 5 cycles, command accepted at once.
    en_cyc = 0;
    wren_cyc = 0;
    bus.app_wdf_rdy = 1'b0;
    push_word(28'd16, W_DB, 1'b1);
    wait_valid(1'b1, "split_dat_valid");
    repeat (5) step();
    bus.app_wdf_rdy = 1'b1;
    wait_count(3, "split_dat_count");
    chk("split_dat_wren_cycles", wren_cyc, 6);
    chk("split_dat_app_en_cycles", en_cyc, 1);
    chk("split_dat_next_addr", bus.app_addr, 28'd24);

    // Wrap across a 4-slot region with five back-to-back words.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wrap_cnt = 0;
    wrap_at = -1;
    push_word(28'd0,  W_12, 1'b1);
    push_word(28'd8,  W_C0, 1'b1);
    push_word(28'd16, W_55, 1'b1);
    push_word(28'd24, W_0F, 1'b1);
    push_word(28'd0,  W_99, 1'b1);
    wait_count(5, "wrap_count");
    chk("wrap_pulses", wrap_cnt, 1);
    chk("wrap_after_commit", wrap_at, 4);
    chk("word_period", rd_gap, 4);
    chk("wrap_next_addr", bus.app_addr, 28'd8);

    // FIFO runs dry: no pops while empty.
    pops = 0;
    push_word(28'd8,  W_A5, 1'b1);
    push_word(28'd16, W_3C, 1'b1);
    wait_count(7, "drain_count");
    repeat (8) step();
    chk("drain_pops", pops, 2);
    chk("drain_busy", busy, 1'b0);

    // en dropped mid-word: that word commits, the next stays in the FIFO.
    pops = 0;
    push_word(28'd24, W_DB, 1'b1);
    push_word(28'd0,  W_12, 1'b1);
    wait_valid(1'b0, "en_drop_valid");
    en = 1'b0;
    wait_count(8, "en_drop_count");
    repeat (10) step();
    chk("en_drop_hold_count", wr_count, 32'd8);
    chk("en_drop_busy", busy, 1'b0);
    chk("en_drop_pops", pops, 1);
    chk("en_drop_fifo_left", fifo_q.size(), 1);
    en = 1'b1;
    wait_count(9, "en_resume_count");
    chk("en_resume_addr", bus.app_addr, 28'd8);

    // Reset in ISSUE with both readies low: word abandoned.
    bus.app_rdy = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    push_word(28'd8, W_C0, 1'b0);
    wait_valid(1'b0, "mid_rst_valid");
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_app_en", bus.app_en, 1'b0);
    chk("mid_rst_wren", bus.app_wdf_wren, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", wr_count, '0);
    chk("mid_rst_addr", bus.app_addr, '0);
    #1;
    rst = 1'b0;
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    push_word(28'd0, W_55, 1'b1);
    wait_count(1, "post_rst_count");

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("cmd_data_paired", cmd_q.size() + dat_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
